window_pingpong_scheduler: RTL and testbench

- Controller that sequences the two-bank ping-pong window FIFO (two 5x16 window banks sharing one pixel input stream).
- Gates writes into the current fill bank and counts beats to decide when a bank is full.
- Hands each full bank to the depthwise/conv consumer in strict FIFO order and releases it after the consumer finishes.
- Sits between the pixel streamer (upstream) and the window banks / MAC array (downstream); runs one frame per start pulse.

---
 rtl/window_pingpong_scheduler.sv | 131 +++++++++++++
 tb/tb_window_pingpong_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_pingpong_scheduler.sv
// Sequencer for the two-bank ping-pong window FIFO. It gates pixel writes into the fill bank,
// hands full banks to the consumer in FIFO order and frees each bank once it has been consumed.
module window_pingpong_scheduler #(
  parameter int unsigned WIN_W  = 12,
  parameter int unsigned ROW_W  = 7,
  parameter int unsigned NWIN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIN_W-1:0]  cfg_window_size,
  input  logic [ROW_W-1:0]  cfg_row_size,
  input  logic              cfg_stride,
  input  logic [NWIN_W-1:0] cfg_num_windows,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        bank_wr_en,
  input  logic [1:0]        bank_data_valid,
  output logic [1:0]        bank_ex_done,
  output logic              zero_buffering,
  output logic [ROW_W-1:0]  row_size_q,
  output logic              stride_q,
  output logic              out_valid,
  output logic              out_bank_sel,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_st_e;

  bank_st_e          bank_st_q [2];
  logic              running_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [WIN_W-1:0]  win_size_q;
  logic [WIN_W-1:0]  beat_cnt_q;
  logic [NWIN_W-1:0] num_win_q;
  logic [NWIN_W-1:0] win_filled_q;
  logic [NWIN_W-1:0] win_done_q;
  logic [1:0]        ex_done_q;
  logic              zero_buf_q;

  logic wr_fire;
  logic rd_fire;
  logic last_beat;

  // The fill bank and the read bank are never the same bank while both fire: a write needs a
  // non-full bank and a read needs a full one.
  assign in_ready     = running_q && (bank_st_q[wr_bank_q] != StFull) &&
                        (win_filled_q < num_win_q);
  assign wr_fire      = in_valid && in_ready;
  assign bank_wr_en   = {wr_fire & wr_bank_q, wr_fire & ~wr_bank_q};
  assign last_beat    = (beat_cnt_q == win_size_q - WIN_W'(1));

  assign out_valid    = running_q && (bank_st_q[rd_bank_q] == StFull) &&
                        bank_data_valid[rd_bank_q];
  assign out_bank_sel = rd_bank_q;
  assign rd_fire      = out_valid && out_ready;
  assign frame_done   = rd_fire && (win_done_q == num_win_q - NWIN_W'(1));

  assign bank_ex_done   = ex_done_q;
  assign zero_buffering = zero_buf_q;
  assign busy           = running_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= StEmpty;
      bank_st_q[1] <= StEmpty;
      running_q    <= 1'b0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      win_size_q   <= '0;
      beat_cnt_q   <= '0;
      num_win_q    <= '0;
      win_filled_q <= '0;
      win_done_q   <= '0;
      row_size_q   <= '0;
      stride_q     <= 1'b0;
      ex_done_q    <= 2'b00;
      zero_buf_q   <= 1'b0;
    end else begin
      ex_done_q  <= {rd_fire & rd_bank_q, rd_fire & ~rd_bank_q};
      zero_buf_q <= frame_done;
      if (!running_q) begin
        if (start && (cfg_window_size != '0) && (cfg_num_windows != '0)) begin
          running_q    <= 1'b1;
          win_size_q   <= cfg_window_size;
          num_win_q    <= cfg_num_windows;
          row_size_q   <= cfg_row_size;
          stride_q     <= cfg_stride;
          beat_cnt_q   <= '0;
          win_filled_q <= '0;
          win_done_q   <= '0;
          wr_bank_q    <= 1'b0;
          rd_bank_q    <= 1'b0;
          bank_st_q[0] <= StEmpty;
          bank_st_q[1] <= StEmpty;
        end
      end else if (frame_done) begin
        // Last window consumed: no writes can be pending, so the whole pipe returns to idle.
        running_q    <= 1'b0;
        beat_cnt_q   <= '0;
        win_filled_q <= '0;
        win_done_q   <= '0;
        wr_bank_q    <= 1'b0;
        rd_bank_q    <= 1'b0;
        bank_st_q[0] <= StEmpty;
        bank_st_q[1] <= StEmpty;
      end else begin
        if (wr_fire) begin
          if (last_beat) begin
            bank_st_q[wr_bank_q] <= StFull;
            beat_cnt_q           <= '0;
            wr_bank_q            <= ~wr_bank_q;
            win_filled_q         <= win_filled_q + NWIN_W'(1);
          end else begin
            bank_st_q[wr_bank_q] <= StFilling;
            beat_cnt_q           <= beat_cnt_q + WIN_W'(1);
          end
        end
        if (rd_fire) begin
          bank_st_q[rd_bank_q] <= StEmpty;
          rd_bank_q            <= ~rd_bank_q;
          win_done_q           <= win_done_q + NWIN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_window_pingpong_scheduler.sv
// Bench for window_pingpong_scheduler: a cycle table for a basic frame, directed corner cases
// and random frames, all checked every cycle against a count-based reference model.
module tb_window_pingpong_scheduler;
  localparam int WIN_W  = 12;
  localparam int ROW_W  = 7;
  localparam int NWIN_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIN_W-1:0]  cfg_window_size;
  logic [ROW_W-1:0]  cfg_row_size;
  logic              cfg_stride;
  logic [NWIN_W-1:0] cfg_num_windows;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        bank_wr_en;
  logic [1:0]        bank_data_valid;
  logic [1:0]        bank_ex_done;
  logic              zero_buffering;
  logic [ROW_W-1:0]  row_size_q;
  logic              stride_q;
  logic              out_valid;
  logic              out_bank_sel;
  logic              out_ready;
  logic              busy;
  logic              frame_done;

  always #5 clk = ~clk;

  window_pingpong_scheduler #(
    .WIN_W (WIN_W),
    .ROW_W (ROW_W),
    .NWIN_W(NWIN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_window_size(cfg_window_size),
    .cfg_row_size   (cfg_row_size),
    .cfg_stride     (cfg_stride),
    .cfg_num_windows(cfg_num_windows),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .bank_wr_en     (bank_wr_en),
    .bank_data_valid(bank_data_valid),
    .bank_ex_done   (bank_ex_done),
    .zero_buffering (zero_buffering),
    .row_size_q     (row_size_q),
    .stride_q       (stride_q),
    .out_valid      (out_valid),
    .out_bank_sel   (out_bank_sel),
    .out_ready      (out_ready),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  int fd_cnt = 0;
  logic [1:0] wen_log [$];

  // Reference model: banks are implied by counts. The fill bank is filled%2, the read bank is
  // done%2, and filled-done is the number of full banks waiting.
  logic             m_run;
  int               m_s, m_n, m_beats, m_filled, m_done;
  logic [ROW_W-1:0] m_row;
  logic             m_str;
  logic [1:0]       m_exd;
  logic             m_zb;
  logic             s_wr, s_rd, s_fd, s_sel;

  typedef struct {
    logic       st;
    logic       iv;
    logic       ordy;
    logic [1:0] dv;
    logic [9:0] exp;  // {in_ready, wr_en, out_valid, sel, ex_done, frame_done, zero_buf, busy}
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic irdy, ov, sel;
    logic [1:0] wen;
    irdy  = m_run && ((m_filled - m_done) < 2) && (m_filled < m_n);
    sel   = (m_done % 2) != 0;
    ov    = m_run && (m_filled > m_done) && bank_data_valid[sel];
    s_wr  = in_valid && irdy;
    s_rd  = ov && out_ready;
    s_sel = sel;
    s_fd  = s_rd && (m_done + 1 == m_n);
    wen   = !s_wr ? 2'b00 : (((m_filled % 2) != 0) ? 2'b10 : 2'b01);
    chk("model_outputs",
        32'({in_ready, bank_wr_en, out_valid, out_bank_sel, bank_ex_done, frame_done,
             zero_buffering, busy, row_size_q, stride_q}),
        32'({irdy, wen, ov, sel, m_exd, s_fd, m_zb, m_run, m_row, m_str}));
  endtask

  task automatic model_update();
    if (rst) begin
      m_run = 1'b0; m_row = '0; m_str = 1'b0; m_exd = 2'b00; m_zb = 1'b0;
      m_s = 0; m_n = 0; m_beats = 0; m_filled = 0; m_done = 0;
    end else begin
      m_exd = s_rd ? (s_sel ? 2'b10 : 2'b01) : 2'b00;
      m_zb  = s_fd;
      if (!m_run) begin
        if (start && cfg_window_size != '0 && cfg_num_windows != '0) begin
          m_run = 1'b1; m_s = int'(cfg_window_size); m_n = int'(cfg_num_windows);
          m_row = cfg_row_size; m_str = cfg_stride;
          m_beats = 0; m_filled = 0; m_done = 0;
        end
      end else if (s_fd) begin
        m_run = 1'b0; m_beats = 0; m_filled = 0; m_done = 0;
      end else begin
        if (s_wr) begin
          m_beats++;
          if (m_beats == m_s) begin
            m_beats = 0;
            m_filled++;
          end
        end
        if (s_rd) m_done++;
      end
    end
  endtask

  task automatic half1();
    @(negedge clk);
    model_check();
    if (bank_wr_en != 2'b00) begin
      n_beats++;
      wen_log.push_back(bank_wr_en);
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic half2();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half1();
    half2();
  endtask

  task automatic do_start(input int s, input int n, input int row, input logic str);
    cfg_window_size = WIN_W'(s);
    cfg_num_windows = NWIN_W'(n);
    cfg_row_size    = ROW_W'(row);
    cfg_stride      = str;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int bound);
    int f0;
    int k;
    f0 = fd_cnt;
    k  = 0;
    while (fd_cnt == f0 && k < bound) begin
      cycle();
      k++;
    end
    chk("frame_done_seen", 32'(fd_cnt - f0), 32'd1);
  endtask

  initial begin
    int f0;
    logic aborted;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 2'b11, 10'b0_00_0_0_00_0_0_0};
    for (int i = 1; i <= 4; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b1_01_0_0_00_0_0_1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b1_10_1_0_00_0_0_1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b1_10_0_1_01_0_0_1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b1_10_0_1_00_0_0_1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b1_10_0_1_00_0_0_1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b0_00_1_1_00_1_0_1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b0_00_0_0_10_0_1_0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b11, 10'b0_00_0_0_00_0_0_0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bank_data_valid = 2'b00;
    cfg_window_size = '0; cfg_row_size = '0; cfg_stride = 1'b0; cfg_num_windows = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk("reset_outputs",
        32'({in_ready, bank_wr_en, bank_ex_done, zero_buffering, row_size_q, stride_q,
             out_valid, out_bank_sel, busy, frame_done}), 32'd0);

    // Basic frame: size 4, two windows, no stalls.
    cfg_window_size = 12'd4; cfg_num_windows = 16'd2; cfg_row_size = 7'd5; cfg_stride = 1'b1;
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      bank_data_valid = tbl[i].dv;
      half1();
      chk($sformatf("table_row%0d", i),
          32'({in_ready, bank_wr_en, out_valid, out_bank_sel, bank_ex_done, frame_done,
               zero_buffering, busy}), 32'(tbl[i].exp));
      half2();
    end
    start = 1'b0;

    // Backpressure: both banks fill, then one accept frees bank 0.
    in_valid = 1'b1; out_ready = 1'b0; bank_data_valid = 2'b11; n_beats = 0;
    do_start(3, 4, 10, 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    chk("bp_beats_accepted", 32'(n_beats), 32'd6);
    chk("bp_in_ready_both_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_in_ready_after_accept", 32'(in_ready), 32'd1);
    chk("bp_ex_done_bank0", 32'(bank_ex_done), 32'd1);
    out_ready = 1'b1;
    run_until_done(200);
    chk("bp_total_beats", 32'(n_beats), 32'd12);

    // Overlap: final beat into bank 1 coincides with the accept of bank 0.
    in_valid = 1'b1; out_ready = 1'b0; n_beats = 0;
    do_start(3, 4, 3, 1'b1);
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    cycle();
    chk("overlap_out_valid_b1", 32'({out_valid, out_bank_sel}), 32'd3);
    chk("overlap_in_ready_b0", 32'(in_ready), 32'd1);
    chk("overlap_ex_done_b0", 32'(bank_ex_done), 32'd1);
    run_until_done(200);
    chk("overlap_total_beats", 32'(n_beats), 32'd12);

    // Data-valid gating.
    in_valid = 1'b1; out_ready = 1'b1; bank_data_valid = 2'b00;
    do_start(2, 1, 4, 1'b0);
    for (int i = 0; i < 6; i++) cycle();
    chk("dv_gated_out_valid", 32'({out_valid, bank_ex_done}), 32'd0);
    bank_data_valid = 2'b01;
    cycle();
    chk("dv_release_ex_done", 32'(bank_ex_done), 32'd1);
    chk("dv_busy_fell", 32'(busy), 32'd0);

    // Window size 1 alternates banks every beat.
    bank_data_valid = 2'b11;
    wen_log.delete();
    do_start(1, 3, 2, 1'b0);
    run_until_done(100);
    chk("size1_beats", 32'(wen_log.size()), 32'd3);
    for (int i = 0; i < wen_log.size(); i++)
      chk($sformatf("size1_wen%0d", i), 32'(wen_log[i]), ((i % 2) != 0) ? 32'd2 : 32'd1);

    // Zero-count and zero-size starts are ignored.
    do_start(4, 0, 1, 1'b0);
    chk("zero_count_busy", 32'(busy), 32'd0);
    do_start(0, 3, 1, 1'b0);
    chk("zero_size_busy", 32'(busy), 32'd0);

    // Start during a frame keeps the latched config.
    in_valid = 1'b0;
    do_start(4, 2, 17, 1'b1);
    do_start(1, 9, 99, 1'b0);
    chk("restart_ignored", 32'({busy, row_size_q, stride_q}), 32'({1'b1, 7'd17, 1'b1}));
    in_valid = 1'b1;
    run_until_done(100);

    // Reset mid-fill, then a fresh frame starts counting from beat 0.
    do_start(4, 2, 6, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midreset_outputs",
        32'({in_ready, bank_wr_en, bank_ex_done, zero_buffering, row_size_q, stride_q,
             out_valid, out_bank_sel, busy, frame_done}), 32'd0);
    out_ready = 1'b0;
    do_start(4, 2, 6, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    chk("midreset_not_full_3", 32'(out_valid), 32'd0);
    cycle();
    chk("midreset_full_4", 32'({out_valid, out_bank_sel}), 32'd2);
    out_ready = 1'b1;
    run_until_done(100);

    // Random frames against the model.
    for (int f = 0; f < 30; f++) begin
      in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
      do_start(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)),
               int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      f0 = fd_cnt;
      aborted = 1'b0;
      for (int k = 0; k < 400 && fd_cnt == f0 && !aborted; k++) begin
        in_valid        = ($urandom_range(0, 3) != 0);
        out_ready       = ($urandom_range(0, 4) < 3);
        bank_data_valid = {($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0)};
        start           = ($urandom_range(0, 19) == 0);
        cfg_row_size    = 7'($urandom_range(0, 127));
        rst             = ($urandom_range(0, 299) == 0);
        cycle();
        if (rst) aborted = 1'b1;
      end
      rst = 1'b0; start = 1'b0;
      chk($sformatf("rand_frame%0d_end", f), 32'((fd_cnt != f0) || aborted), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
